// File: rtl/vga_scan_timing_if.sv
// Renderer-facing scan coordinates, returned pixel word and the physical VGA pins.
interface vga_scan_timing_if;
  logic [8:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic [15:0] pixel_data;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        vga_hsync_n;
  logic        vga_vsync_n;
  logic        vga_blank_n;

  modport master (
    output x, y, frame_start,
    output vga_r, vga_g, vga_b, vga_hsync_n, vga_vsync_n, vga_blank_n,
    input  pixel_data
  );

  modport slave (
    input  x, y, frame_start,
    input  vga_r, vga_g, vga_b, vga_hsync_n, vga_vsync_n, vga_blank_n,
    output pixel_data
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA scan timing generator: counters feed the renderer, delayed sync/blank
// re-align with the returned pixel word at the output register.
module vga_scan_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_timing_if.master bus
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       active_raw, hs_raw, vs_raw, frame_start_d;

  logic [PIPE_DELAY-1:0] active_q, hs_q, vs_q;
  logic [PIPE_DELAY:0]   active_sr_d, hs_sr_d, vs_sr_d;

  logic [4:0] r_q, r_d;
  logic [5:0] g_q, g_d;
  logic [4:0] b_q, b_d;
  logic       blank_n_q, hsync_n_q, vsync_n_q, frame_start_q;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 10'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == 10'(V_TOTAL - 1)) ? '0 : vcnt_q + 10'd1;
    end
  end

  assign active_raw    = (hcnt_q < 10'(H_VISIBLE)) && (vcnt_q < 10'(V_VISIBLE));
  assign hs_raw        = (hcnt_q >= 10'(HS_START)) && (hcnt_q < 10'(HS_END));
  assign vs_raw        = (vcnt_q >= 10'(VS_START)) && (vcnt_q < 10'(VS_END));
  assign frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);

  // Stage boundary: raw controls shift PIPE_DELAY deep to match renderer latency
  always_comb begin
    active_sr_d = {active_q, active_raw};
    hs_sr_d     = {hs_q, hs_raw};
    vs_sr_d     = {vs_q, vs_raw};
  end

  // Stage boundary: output register, colour forced to zero outside the window
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active_q[PIPE_DELAY-1]) begin
      r_d = bus.pixel_data[15:11];
      g_d = bus.pixel_data[10:5];
      b_d = bus.pixel_data[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      active_q      <= '0;
      hs_q          <= '0;
      vs_q          <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      blank_n_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      active_q      <= active_sr_d[PIPE_DELAY-1:0];
      hs_q          <= hs_sr_d[PIPE_DELAY-1:0];
      vs_q          <= vs_sr_d[PIPE_DELAY-1:0];
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      blank_n_q     <= active_q[PIPE_DELAY-1];
      hsync_n_q     <= ~hs_q[PIPE_DELAY-1];
      vsync_n_q     <= ~vs_q[PIPE_DELAY-1];
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.x           = hcnt_q[9:1];
  assign bus.y           = vcnt_q[9:1];
  assign bus.frame_start = frame_start_q;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_hsync_n = hsync_n_q;
  assign bus.vga_vsync_n = vsync_n_q;
endmodule
